// File: rtl/botao_seletor_if.sv
// Button/page-select bundle between the raw button, the conditioner and the display.
interface botao_seletor_if;
    logic botao_in;   // raw mechanical button, 1 = pressed, asynchronous
    logic botao;      // page select: 0 = page 0, 1 = page 1
    logic pulso;      // one-cycle strobe per debounced press
    logic estavel;    // debounced button level

    // Driver side: the button source, which also observes the conditioned outputs
    modport master (
        output botao_in,
        input  botao,
        input  pulso,
        input  estavel
    );

    // Conditioner side
    modport slave (
        input  botao_in,
        output botao,
        output pulso,
        output estavel
    );
endinterface

// File: rtl/botao_seletor.sv
// Button conditioner: two-flop synchronizer, counter debounce, press strobe and a
// two-page toggle FSM with an optional inactivity timeout back to page 0.
module botao_seletor #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic           clk,
    input  logic           reset_n,
    botao_seletor_if.slave bus
);

    // Counter widths only need to reach the terminal value N-1.
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        PAGINA0 = 1'b0,
        PAGINA1 = 1'b1
    } state_t;

    logic          sync1_q;
    logic          sync_q;
    logic          estavel_q, estavel_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          pulso_q,   pulso_d;
    logic          press;
    state_t        state_q,   state_d;
    logic [TW-1:0] timer_q,   timer_d;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= bus.botao_in;
            sync_q  <= sync1_q;
        end
    end

    // Debounce: the level follows sync only after an unbroken run of disagreement
    always_comb begin
        estavel_d = estavel_q;
        deb_cnt_d = '0;
        press     = 1'b0;
        if (sync_q != estavel_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                estavel_d = sync_q;
                // Only the 0->1 transition is a press; releases are silent.
                press     = sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
        pulso_d = press;
    end

    // Debounce registers and the press strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estavel_q <= 1'b0;
            deb_cnt_q <= '0;
            pulso_q   <= 1'b0;
        end else begin
            estavel_q <= estavel_d;
            deb_cnt_q <= deb_cnt_d;
            pulso_q   <= pulso_d;
        end
    end

    // FSM state register together with its inactivity timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PAGINA0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // FSM next state: a press toggles the page; page 1 also expires after the timeout.
    // A press landing on the expiry edge is absorbed, so the result is page 0 either way.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            PAGINA0: begin
                if (press) begin
                    state_d = PAGINA1;
                end
            end
            PAGINA1: begin
                if (press) begin
                    state_d = PAGINA0;
                end else if (TMO_EN) begin
                    if (timer_q == TMO_LAST) begin
                        state_d = PAGINA0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = PAGINA0;
            end
        endcase
    end

    // FSM outputs: the page bit is the state itself; all outputs come straight from flops
    always_comb begin
        bus.botao   = (state_q == PAGINA1);
        bus.pulso   = pulso_q;
        bus.estavel = estavel_q;
    end

endmodule

// File: tb/tb_botao_seletor.sv
// Directed bench for botao_seletor with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_botao_seletor;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    botao_seletor_if bus ();

    botao_seletor #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.botao_in = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== 3'b000 || dut.timer_q !== '0 || dut.deb_cnt_q !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold edge %0d: got botao/pulso/estavel=%b timer=%0d cnt=%0d, expected 000 0 0",
                         n, {bus.botao, bus.pulso, bus.estavel}, dut.timer_q, dut.deb_cnt_q);
            end
        end
        reset_n = 1'b1;
        step();
        bus.botao_in = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_release edge %0d: got %b expected 000", n, {bus.botao, bus.pulso, bus.estavel});
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_press();
        bus.botao_in = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            logic [2:0] exp_v;
            step();
            exp_v = {(n >= 6), (n == 6), (n >= 6)};
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== exp_v) begin
                tests_failed++;
                $display("FAIL clean_press edge %0d: got botao/pulso/estavel=%b expected %b",
                         n, {bus.botao, bus.pulso, bus.estavel}, exp_v);
            end
        end
        $display("[TB] test_clean_press done");
    endtask

    task automatic test_release_second();
        bus.botao_in = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            logic [2:0] exp_v;
            step();
            exp_v = {1'b1, 1'b0, (n < 6)};
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== exp_v) begin
                tests_failed++;
                $display("FAIL release edge %0d: got %b expected %b", n, {bus.botao, bus.pulso, bus.estavel}, exp_v);
            end
        end
        bus.botao_in = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            logic [2:0] exp_v;
            step();
            exp_v = (n < 6) ? 3'b100 : {1'b0, (n == 6), 1'b1};
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== exp_v) begin
                tests_failed++;
                $display("FAIL second_press edge %0d: got %b expected %b", n, {bus.botao, bus.pulso, bus.estavel}, exp_v);
            end
        end
        bus.botao_in = 1'b0;
        repeat (8) step();
        $display("[TB] test_release_second done");
    endtask

    task automatic test_bounce();
        for (int n = 0; n < 30; n++) begin
            bus.botao_in = (((n / 3) % 2) == 0);
            step();
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== 3'b000) begin
                tests_failed++;
                $display("FAIL bounce cycle %0d: got %b expected 000", n, {bus.botao, bus.pulso, bus.estavel});
            end
        end
        bus.botao_in = 1'b0;
        repeat (8) step();
        $display("[TB] test_bounce done");
    endtask

    // Quick press / release / press well inside the timeout: the second press alone must toggle back
    task automatic test_back_to_back();
        logic [2:0] exp_v;
        bus.botao_in = 1'b1;
        repeat (6) step();
        tests_run++;
        if ({bus.botao, bus.pulso, bus.estavel} !== 3'b111) begin
            tests_failed++;
            $display("FAIL b2b_first: got %b expected 111", {bus.botao, bus.pulso, bus.estavel});
        end
        bus.botao_in = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            exp_v = {1'b1, 1'b0, (n < 6)};
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_release edge %0d: got %b expected %b", n, {bus.botao, bus.pulso, bus.estavel}, exp_v);
            end
        end
        bus.botao_in = 1'b1;
        repeat (6) step();
        tests_run++;
        if ({bus.botao, bus.pulso, bus.estavel} !== 3'b011) begin
            tests_failed++;
            $display("FAIL b2b_second: got %b expected 011", {bus.botao, bus.pulso, bus.estavel});
        end
        bus.botao_in = 1'b0;
        repeat (8) step();
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_timeout();
        // Run A: press at edge 6 and hold; page 1 must expire at edge 26
        bus.botao_in = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            logic [1:0] exp_v;
            step();
            exp_v = {(n >= 6 && n < 26), (n == 6)};
            tests_run++;
            if ({bus.botao, bus.pulso} !== exp_v) begin
                tests_failed++;
                $display("FAIL timeout_plain edge %0d: got botao/pulso=%b expected %b", n, {bus.botao, bus.pulso}, exp_v);
            end
        end
        tests_run++;
        if (dut.timer_q !== '0) begin
            tests_failed++;
            $display("FAIL timeout_plain_timer: got %0d expected 0", dut.timer_q);
        end
        bus.botao_in = 1'b0;
        repeat (8) step();

        // Run B: a second press debounces exactly on the expiry edge 26
        bus.botao_in = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            logic [1:0] exp_v;
            if (n == 7)  bus.botao_in = 1'b0;
            if (n == 21) bus.botao_in = 1'b1;
            step();
            exp_v = {(n >= 6 && n < 26), (n == 6 || n == 26)};
            tests_run++;
            if ({bus.botao, bus.pulso} !== exp_v) begin
                tests_failed++;
                $display("FAIL timeout_press edge %0d: got botao/pulso=%b expected %b", n, {bus.botao, bus.pulso}, exp_v);
            end
            if (n == 26) begin
                tests_run++;
                if (dut.timer_q !== '0) begin
                    tests_failed++;
                    $display("FAIL timeout_press_timer: got %0d expected 0", dut.timer_q);
                end
            end
        end
        bus.botao_in = 1'b0;
        repeat (8) step();
        $display("[TB] test_timeout done");
    endtask

    task automatic test_async_reset();
        // Put the design in page 1 with the button released
        bus.botao_in = 1'b1;
        repeat (6) step();
        bus.botao_in = 1'b0;
        repeat (6) step();
        tests_run++;
        if ({bus.botao, bus.estavel} !== 2'b10) begin
            tests_failed++;
            $display("FAIL arst_precond: got botao/estavel=%b expected 10", {bus.botao, bus.estavel});
        end
        bus.botao_in = 1'b1;
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.botao, bus.pulso, bus.estavel} !== 3'b000 || dut.deb_cnt_q !== '0 || dut.sync_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_immediate: got %b cnt=%0d sync=%b expected 000 cnt=0 sync=0",
                     {bus.botao, bus.pulso, bus.estavel}, dut.deb_cnt_q, dut.sync_q);
        end
        #2;
        reset_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            logic [2:0] exp_v;
            step();
            exp_v = {(n >= 6), (n == 6), (n >= 6)};
            tests_run++;
            if ({bus.botao, bus.pulso, bus.estavel} !== exp_v) begin
                tests_failed++;
                $display("FAIL arst_recover edge %0d: got %b expected %b", n, {bus.botao, bus.pulso, bus.estavel}, exp_v);
            end
        end
        bus.botao_in = 1'b0;
        repeat (8) step();
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        bus.botao_in = 1'b0;
        test_reset();
        test_clean_press();
        test_release_second();
        test_bounce();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/botao_seletor.md
# botao_seletor

Button conditioner directly upstream of the three-digit card display. It synchronizes and debounces the raw push-button and turns each debounced press into a toggle of the page-select level `botao`. The display consumes `botao` to choose between its two fixed digit patterns. An optional inactivity timeout returns the display to page 0.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles of changed synchronized input required before the debounced level follows it. Must be ≥ 1.
- `TIMEOUT_CYCLES`, default 250000000: cycles spent in page 1 without a press before an automatic return to page 0. A value of 0 disables the timeout.

Ports:
- `clk`  input  1  single system clock; everything is rising-edge.
- `reset_n`  input  1  reset, asynchronous and active-low.
- `botao_in`  input  1  raw mechanical button, 1 = pressed, asynchronous to `clk`.
- `botao`  output  1  page select to the display; 0 = page 0, 1 = page 1.
- `pulso`  output  1  single-cycle strobe on each debounced press (0→1).
- `estavel`  output  1  debounced button level.

## Operation

- **Reset.** `reset_n` = 0 immediately clears all of the following, without waiting for a clock edge:
  - both synchronizer flops
  - `estavel`, `pulso`, `botao`
  - debounce counter and timeout timer
  - FSM, which goes to PAGINA0
- **Reset mid-operation.** Any partial debounce count or timer value is discarded.
- **Synchronizer.** Two flops on `botao_in`; the second flop's output is `sync`.
- **Debounce.**
  - If `sync` == `estavel`: counter ← 0.
  - If they differ and counter == `DEBOUNCE_CYCLES`-1: `estavel` ← `sync`, counter ← 0.
  - If they differ otherwise: counter increments.
  - Any single cycle of agreement restarts the count, so bounces shorter than `DEBOUNCE_CYCLES` are rejected.
  - The counter width must hold `DEBOUNCE_CYCLES`-1 and never wraps.
- **Press event.** A press is the clock edge that updates `estavel` from 0 to 1.
  - `pulso` is registered and is 1 only in the cycle immediately after that edge.
  - A release (`estavel` 1→0) produces no pulse.
- **FSM.** Two states, with `botao` = state bit.
  - PAGINA0 + press → PAGINA1; timer ← 0.
  - PAGINA1 + press → PAGINA0; timer ← 0.
  - PAGINA1, no press, `TIMEOUT_CYCLES` ≠ 0: timer increments each cycle. At the edge where timer == `TIMEOUT_CYCLES`-1 → PAGINA0, timer ← 0.
  - PAGINA0: timer is held at 0.
  - Press and timeout on the same edge: result is PAGINA0 with timer 0. The press is consumed and does not re-toggle.
  - `TIMEOUT_CYCLES` = 0: the timer stays at 0 and PAGINA1 is left only by a press.
  - The timer width must hold `TIMEOUT_CYCLES`-1.
- **Holding the button.** A held button produces exactly one press, whatever the hold duration.

## Timing

- All outputs are registered; there is no combinational path from `botao_in`.
- Input change present before edge 0 and held stable:
  - `sync` changes after edge 2.
  - `estavel` changes after edge `DEBOUNCE_CYCLES`+2.
  - On a press, `pulso` and `botao` change after that same edge.
  - `pulso` falls after the next edge.
- Timeout: entering PAGINA1 after edge E gives `botao` = 0 after edge E+`TIMEOUT_CYCLES`.
- Minimum press-to-press spacing: 2·`DEBOUNCE_CYCLES` cycles (a debounced release must occur between presses).

## Test plan

Bench settings: `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=20; edge n = nth rising edge after stimulus.

1. **Reset.** Hold `reset_n`=0 with `botao_in`=1, release, then drive `botao_in`=0 → `botao`, `pulso`, `estavel` = 0 throughout.
2. **Clean press.** `botao_in` 0→1 before edge 0, held 12 cycles → after edge 6: `estavel`=1, `pulso`=1, `botao`=1. After edge 7: `pulso`=0, and it stays 0 for the rest of the hold.
3. **Bounce rejection.** `botao_in` alternating 3 cycles high / 3 cycles low for 30 cycles → `estavel`, `pulso`, `botao` unchanged at 0.
4. **Release and second press.** After scenario 2, release for 8 cycles, then press again → on release, `estavel` falls with no pulse and `botao` stays 1. On the second press, `pulso` is high for 1 cycle and `botao`=0.
5. **Timeout.** Press enters PAGINA1 at edge 6; no further input → `botao`=0 after edge 26. A press arriving exactly on edge 26 also yields `botao`=0 and timer 0.
6. **Async reset mid-debounce.** Press, assert `reset_n`=0 between edges 4 and 5 (no clock edge) → outputs 0 immediately. After release with `botao_in` still 1, `estavel` rises 6 edges later.
